grammer_out_buffer: RTL and testbench

//  Downstream stage of the 32-bit array/compute stage: captures its per-cycle result word stream,

---
 rtl/grammer_pkg.sv | 15 +
 rtl/gob_fifo_mem.sv | 52 +++++
 rtl/grammer_out_buffer.sv | 142 ++++++++++++++
 tb/tb_grammer_out_buffer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/grammer_pkg.sv
// Shared types and defaults for the grammer output buffer.
// Optional checksum logic in the top level is enabled by defining GOB_CHECKSUM_EN.
package grammer_pkg;

  localparam int GOB_DATA_W = 32;
  localparam int GOB_DEPTH  = 4;

  // Occupancy-based control state of the output FIFO.
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } gob_state_t;

endpackage

// File: rtl/gob_fifo_mem.sv
// Storage for the output buffer: DEPTH x DATA_W register array with one write
// port and one registered read port. A same-cycle write to the address being
// read is forwarded, so the read register always holds the current head word.
module gob_fifo_mem
  import grammer_pkg::*;
#(
  parameter int DATA_W = GOB_DATA_W,
  parameter int DEPTH  = GOB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Select the word to register: forward the incoming write when it targets the read address.
  always_comb begin
    rdata_d = mem_q[raddr];
    if (we && (waddr == raddr)) begin
      rdata_d = wdata;
    end
  end

  // Array write port.
  // NOTE: the array has no reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Registered read port, cleared by reset so dout starts at zero.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/grammer_out_buffer.sv
// Output buffer behind the 32-bit compute stage: first-word fall-through FIFO
// with drop-on-full, sticky overflow, accepted-word counter and synchronous flush.
// Define GOB_CHECKSUM_EN to add the rotate-xor checksum port over accepted words.
module grammer_out_buffer
  import grammer_pkg::*;
#(
  parameter int DATA_W = GOB_DATA_W,
  parameter int DEPTH  = GOB_DEPTH,
  parameter int CNT_W  = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              flush,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  output logic [CNT_W-1:0]  accept_cnt
`ifdef GOB_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  gob_state_t        state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  accept_cnt_q, accept_cnt_d;
`ifdef GOB_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

  logic push;
  logic pop;
  logic mem_we;

  assign pop    = (state_q != EMPTY) && dout_ready;
  assign push   = din_valid && ((state_q != FULL) || pop);
  assign mem_we = push && !flush;

  // Next-state logic: flush wins over push/pop; otherwise apply push and pop together.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    accept_cnt_d = accept_cnt_q;
`ifdef GOB_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      state_d  = EMPTY;
    end else begin
      if (push) begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(1);
        accept_cnt_d = accept_cnt_q + CNT_W'(1);
`ifdef GOB_CHECKSUM_EN
        checksum_d   = {checksum_q[DATA_W-2:0], checksum_q[DATA_W-1]} ^ din;
`endif
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (din_valid && !push) begin
        overflow_d = 1'b1;
      end
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
      if (level_d == '0) begin
        state_d = EMPTY;
      end else if (level_d == LVL_W'(DEPTH)) begin
        state_d = FULL;
      end else begin
        state_d = ACTIVE;
      end
    end
  end

  // Control FSM and bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      accept_cnt_q <= '0;
`ifdef GOB_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      accept_cnt_q <= accept_cnt_d;
`ifdef GOB_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  // Reading at the next read pointer keeps dout equal to the head word after every edge.
  gob_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (reset),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_d),
    .rdata (dout)
  );

  assign dout_valid = (state_q != EMPTY);
  assign empty      = (state_q == EMPTY);
  assign full       = (state_q == FULL);
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign accept_cnt = accept_cnt_q;
`ifdef GOB_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_grammer_out_buffer.sv
// Directed self-checking bench for grammer_out_buffer (DEPTH=4, DATA_W=32, CNT_W=16).
module tb_grammer_out_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din;
  logic        din_valid;
  logic        flush;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        full;
  logic        empty;
  logic [2:0]  level;
  logic        overflow;
  logic [15:0] accept_cnt;
`ifdef GOB_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  grammer_out_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .flush      (flush),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .accept_cnt (accept_cnt)
`ifdef GOB_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    din       = w;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  logic [31:0] a_words [5];
  logic [31:0] b_words [5];
  logic [15:0] cnt_before;

  initial begin
    reset      = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    flush      = 1'b0;
    dout_ready = 1'b0;
    a_words = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004, 32'hA000_0005};
    b_words = '{32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hB000_0004, 32'hB000_0005};
    step();
    step();

    // Reset values
    check("rst_level",      32'(level), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_empty",      32'(empty), 32'd1);
    check("rst_full",       32'(full), 32'd0);
    check("rst_dout",       dout, 32'd0);
    check("rst_overflow",   32'(overflow), 32'd0);
    check("rst_accept_cnt", 32'(accept_cnt), 32'd0);
    reset = 1'b0;
    step();

    // Fill to full with consumer stalled, then drop one word
    for (int i = 0; i < 4; i++) begin
      push(a_words[i]);
      check("fill_level", 32'(level), 32'(i + 1));
      check("fill_head", dout, a_words[0]);
    end
    check("full_flag", 32'(full), 32'd1);
    check("full_level", 32'(level), 32'd4);
    check("full_no_ovf", 32'(overflow), 32'd0);
    push(a_words[4]);
    check("drop_overflow", 32'(overflow), 32'd1);
    check("drop_accept_cnt", 32'(accept_cnt), 32'd4);
    check("drop_level", 32'(level), 32'd4);
    check("drop_head", dout, a_words[0]);
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(dout_valid), 32'd1);
      check("drain_data", dout, a_words[i]);
      step();
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_valid_low", 32'(dout_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    dout_ready = 1'b0;

    // Reset mid-stream at level 3
    push(32'h1111_1111);
    push(32'h2222_2222);
    push(32'h3333_3333);
    check("mid_level3", 32'(level), 32'd3);
    reset = 1'b1;
    #1;
    check("async_rst_level", 32'(level), 32'd0);
    step();
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_valid", 32'(dout_valid), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_accept_cnt", 32'(accept_cnt), 32'd0);
    reset = 1'b0;
    step();

    // Push and pop together while full
    for (int i = 0; i < 4; i++) push(b_words[i]);
    check("pp_full", 32'(full), 32'd1);
    din        = b_words[4];
    din_valid  = 1'b1;
    dout_ready = 1'b1;
    step();
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    check("pp_level", 32'(level), 32'd4);
    check("pp_overflow", 32'(overflow), 32'd0);
    check("pp_accept_cnt", 32'(accept_cnt), 32'd5);
    dout_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("pp_order", dout, b_words[i]);
      step();
    end
    check("pp_empty", 32'(empty), 32'd1);
    dout_ready = 1'b0;

    // Single word fall-through, then held while stalled
    push(32'hDEAD_BEEF);
    check("fwft_valid", 32'(dout_valid), 32'd1);
    check("fwft_data", dout, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_data", dout, 32'hDEAD_BEEF);
      check("hold_valid", 32'(dout_valid), 32'd1);
    end
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    check("fwft_popped", 32'(empty), 32'd1);

    // Flush with a word arriving in the same cycle
    push(32'hC000_0001);
    push(32'hC000_0002);
    check("pre_flush_level", 32'(level), 32'd2);
    cnt_before = accept_cnt;
    flush     = 1'b1;
    din       = 32'hC000_0003;
    din_valid = 1'b1;
    step();
    flush     = 1'b0;
    din_valid = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_valid", 32'(dout_valid), 32'd0);
    check("flush_accept_cnt", 32'(accept_cnt), 32'(cnt_before));
    push(32'hD000_0001);
    check("post_flush_level", 32'(level), 32'd1);
    check("post_flush_head", dout, 32'hD000_0001);

`ifdef GOB_CHECKSUM_EN
    do_reset();
    check("cks_reset", checksum, 32'd0);
    push(32'h1);
    check("cks_first", checksum, 32'h1);
    push(32'h2);
    check("cks_second", checksum, 32'h0);
`endif

    // Accepted-word counter wrap, consumer always ready
    do_reset();
    dout_ready = 1'b1;
    din_valid  = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      din = 32'(i);
      step();
    end
    check("cnt_max", 32'(accept_cnt), 32'h0000_FFFF);
    check("cnt_no_ovf", 32'(overflow), 32'd0);
    step();
    din_valid = 1'b0;
    check("cnt_wrap", 32'(accept_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
